// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared time-code constants and decode helpers
package smart_home_pkg;

  localparam logic [3:0] TC_OFF  = 4'b0000;
  localparam logic [3:0] TC_T1   = 4'b0001;
  localparam logic [3:0] TC_T2   = 4'b0010;
  localparam logic [3:0] TC_USER = 4'b0100;
  localparam logic [3:0] TC_T3   = 4'b1000;

  // Source a shade channel picks its target from when no override is active
  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_T1,
    SEL_T2,
    SEL_USER,
    SEL_HOLD
  } tsel_e;

  function automatic logic tcode_legal(input logic [3:0] tc);
    return (tc == TC_OFF) || (tc == TC_T1) || (tc == TC_T2) ||
           (tc == TC_USER) || (tc == TC_T3);
  endfunction

  function automatic tsel_e tcode_decode(input logic [3:0] tc);
    tsel_e sel;
    case (tc)
      TC_OFF, TC_T3: sel = SEL_ZERO;
      TC_T1:         sel = SEL_T1;
      TC_T2:         sel = SEL_T2;
      TC_USER:       sel = SEL_USER;
      default:       sel = SEL_HOLD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/shade_channel.sv
// rtl/shade_channel.sv - per-window target register and one-level-per-tick slew
module shade_channel
  import smart_home_pkg::*;
#(
  parameter int                 LEVEL_W = 4,
  parameter logic [LEVEL_W-1:0] LVL_T1  = {LEVEL_W{1'b1}},
  parameter logic [LEVEL_W-1:0] LVL_T2  = LEVEL_W'(12)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_tick_i,
  input  tsel_e              tsel_i,
  input  logic [LEVEL_W-1:0] ulight_i,
  input  logic               ovr_en_i,
  input  logic [LEVEL_W-1:0] ovr_lvl_i,
  output logic [LEVEL_W-1:0] wshade_o,
  output logic [LEVEL_W-1:0] target_o,
  output logic               moving_o
);

  logic [LEVEL_W-1:0] target_d, target_q;
  logic [LEVEL_W-1:0] pos_d, pos_q;

  always_comb begin
    target_d = target_q;
    if (ovr_en_i) begin
      target_d = ovr_lvl_i;
    end else begin
      case (tsel_i)
        SEL_ZERO: target_d = '0;
        SEL_T1:   target_d = LVL_T1;
        SEL_T2:   target_d = LVL_T2;
        SEL_USER: target_d = ulight_i;
        default:  target_d = target_q;
      endcase
    end
  end

  // Slew compares against the registered target, so a same-cycle target
  // change only steers the following tick; the strict compares rule out wrap.
  always_comb begin
    pos_d = pos_q;
    if (step_tick_i) begin
      if (pos_q < target_q) begin
        pos_d = pos_q + 1'b1;
      end else if (pos_q > target_q) begin
        pos_d = pos_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      pos_q    <= '0;
    end else begin
      target_q <= target_d;
      pos_q    <= pos_d;
    end
  end

  assign wshade_o = pos_q;
  assign target_o = target_q;
  assign moving_o = (pos_q != target_q);

endmodule

// File: rtl/window_shade_controller.sv
// rtl/window_shade_controller.sv - multi-window shade controller with shared step prescaler
module window_shade_controller
  import smart_home_pkg::*;
#(
  parameter int                 N_WIN    = 4,
  parameter int                 LEVEL_W  = 4,
  parameter int                 STEP_DIV = 1000,
  parameter logic [LEVEL_W-1:0] LVL_T1   = {LEVEL_W{1'b1}},
  parameter int                 LVL_T2   = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               tcode,
  input  logic [N_WIN*LEVEL_W-1:0] ulight,
  input  logic [N_WIN-1:0]         ovr_en,
  input  logic [N_WIN*LEVEL_W-1:0] ovr_lvl,
  output logic [N_WIN*LEVEL_W-1:0] wshade,
  output logic [N_WIN*LEVEL_W-1:0] target,
  output logic [N_WIN-1:0]         moving,
  output logic                     tcode_err
);

  localparam int               CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             step_tick;
  logic             tcode_err_q;
  tsel_e            tsel;

  // With STEP_DIV=1 the counter sits at 0 == CNT_MAX, so every cycle ticks
  assign step_tick = (cnt_q == CNT_MAX);
  assign cnt_d     = step_tick ? '0 : cnt_q + 1'b1;
  assign tsel      = tcode_decode(tcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      tcode_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tcode_err_q <= ~tcode_legal(tcode);
    end
  end

  assign tcode_err = tcode_err_q;

  for (genvar i = 0; i < N_WIN; i++) begin : g_win
    shade_channel #(
      .LEVEL_W (LEVEL_W),
      .LVL_T1  (LVL_T1),
      .LVL_T2  (LEVEL_W'(LVL_T2))
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_tick_i (step_tick),
      .tsel_i      (tsel),
      .ulight_i    (ulight[i*LEVEL_W +: LEVEL_W]),
      .ovr_en_i    (ovr_en[i]),
      .ovr_lvl_i   (ovr_lvl[i*LEVEL_W +: LEVEL_W]),
      .wshade_o    (wshade[i*LEVEL_W +: LEVEL_W]),
      .target_o    (target[i*LEVEL_W +: LEVEL_W]),
      .moving_o    (moving[i])
    );
  end

endmodule
